// File: rtl/codec_config_sequencer.sv
// Walks the fixed WM8731 register table, handing one word at a time to the I2C master,
// with per-word retry, transaction time-out and done/error status reporting.
module codec_config_sequencer #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_go,
  input  logic        i_i2c_ready,
  input  logic        i_i2c_done,
  input  logic        i_i2c_ack_err,
  output logic        o_i2c_start,
  output logic [15:0] o_i2c_data,
  output logic        o_busy,
  output logic        o_config_done,
  output logic        o_config_error,
  output logic [3:0]  o_word_index
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CYCLES - 1);
  localparam logic [15:0]       TmoLast  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]       TmoSat   = 16'hFFFF;
  localparam logic [3:0]        LastWord = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StCheck,
    StGap,
    StDone,
    StError
  } state_e;

  function automatic logic [15:0] f_table(input logic [3:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = 16'h1E00;
      4'd1:    word = 16'h0017;
      4'd2:    word = 16'h0217;
      4'd3:    word = 16'h0479;
      4'd4:    word = 16'h0679;
      4'd5:    word = 16'h0812;
      4'd6:    word = 16'h0A00;
      4'd7:    word = 16'h0C00;
      4'd8:    word = 16'h0E02;
      4'd9:    word = 16'h1000;
      4'd10:   word = 16'h1201;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_word, w_word_nxt;
  logic [RetryW-1:0]   r_retry, w_retry_nxt, w_retry_inc;
  logic [15:0]         r_tmo, w_tmo_nxt;
  logic [GapW-1:0]     r_gap, w_gap_nxt;
  logic                r_fail, w_fail_nxt;
  logic [15:0]         r_data, w_data_nxt;
  logic                r_start, w_start_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;

  assign w_retry_inc = r_retry + RetryW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_retry_nxt = r_retry;
    w_tmo_nxt   = r_tmo;
    w_gap_nxt   = r_gap;
    w_fail_nxt  = r_fail;
    w_data_nxt  = r_data;
    w_start_nxt = 1'b0;
    w_done_nxt  = r_done;
    w_error_nxt = r_error;

    case (r_state)
      StIdle, StDone, StError: begin
        if (i_go) begin
          w_word_nxt  = 4'd0;
          w_retry_nxt = '0;
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        w_data_nxt  = f_table(r_word);
        // Request is registered, so decide now to have it visible in the first START cycle.
        w_start_nxt = i_i2c_ready;
        w_state_nxt = StStart;
      end
      StStart: begin
        if (r_start) begin
          w_tmo_nxt   = '0;
          w_state_nxt = StWait;
        end else begin
          w_start_nxt = i_i2c_ready;
        end
      end
      StWait: begin
        if (i_i2c_done) begin
          w_fail_nxt  = i_i2c_ack_err;
          w_state_nxt = StCheck;
        end else if (r_tmo == TmoLast) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = StCheck;
        end else if (r_tmo != TmoSat) begin
          w_tmo_nxt = r_tmo + 16'd1;
        end
      end
      StCheck: begin
        w_gap_nxt = '0;
        if (!r_fail) begin
          w_retry_nxt = '0;
          if (r_word == LastWord) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_word_nxt  = r_word + 4'd1;
            w_state_nxt = StGap;
          end
        end else begin
          w_retry_nxt = w_retry_inc;
          if (w_retry_inc == RetryMax) begin
            w_error_nxt = 1'b1;
            w_state_nxt = StError;
          end else begin
            w_state_nxt = StGap;
          end
        end
      end
      StGap: begin
        if (r_gap == GapLast) begin
          w_state_nxt = StLoad;
        end else begin
          w_gap_nxt = r_gap + GapW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    w_busy_nxt = !(w_state_nxt == StIdle || w_state_nxt == StDone || w_state_nxt == StError);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_word  <= 4'd0;
      r_retry <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_fail  <= 1'b0;
      r_data  <= 16'h0000;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_retry <= w_retry_nxt;
      r_tmo   <= w_tmo_nxt;
      r_gap   <= w_gap_nxt;
      r_fail  <= w_fail_nxt;
      r_data  <= w_data_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  assign o_i2c_start    = r_start;
  assign o_i2c_data     = r_data;
  assign o_busy         = r_busy;
  assign o_config_done  = r_done;
  assign o_config_error = r_error;
  assign o_word_index   = r_word;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer: a simple I2C responder model plus
// hand-computed expectations for sequencing, retry, time-out, back-pressure and reset.
module tb_codec_config_sequencer;

  localparam int unsigned Gap   = 16;
  localparam int unsigned Retry = 3;
  localparam int unsigned Tmo   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        rdy = 1'b1;
  logic        done_i = 1'b0;
  logic        ack = 1'b0;
  logic        o_start;
  logic [15:0] o_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [3:0]  o_idx;

  always #5 clk = ~clk;

  codec_config_sequencer #(
    .GAP_CYCLES    (Gap),
    .MAX_RETRY     (Retry),
    .TIMEOUT_CYCLES(Tmo)
  ) u_dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_go          (go),
    .i_i2c_ready   (rdy),
    .i_i2c_done    (done_i),
    .i_i2c_ack_err (ack),
    .o_i2c_start   (o_start),
    .o_i2c_data    (o_data),
    .o_busy        (o_busy),
    .o_config_done (o_done),
    .o_config_error(o_error),
    .o_word_index  (o_idx)
  );

  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                            16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Responder configuration, written only by the main sequence.
  int nack_idx = -1;
  bit nack_all = 1'b0;
  int hold_idx = -1;
  int epoch    = 0;

  // Responder observations, written only by the responder.
  logic [15:0] log_d [$];
  int          log_c [$];
  int          viol = 0;
  int          cyc  = 0;

  initial begin : responder
    int   cd;
    int   cur;
    int   seen;
    int   att [11];
    logic prev;
    cd   = 0;
    cur  = 0;
    seen = 0;
    prev = 1'b0;
    foreach (att[i]) att[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      done_i = 1'b0;
      ack    = 1'b0;
      if (seen != epoch) begin
        foreach (att[i]) att[i] = 0;
        seen = epoch;
      end
      if (!rst_n) begin
        cd   = 0;
        prev = 1'b0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0 && cur != hold_idx) begin
            done_i = 1'b1;
            ack    = (cur == nack_idx) && (nack_all || att[cur] == 1);
          end
        end
        if (o_start) begin
          if (prev || !rdy) viol++;
          log_d.push_back(o_data);
          log_c.push_back(cyc);
          cur = int'(o_idx);
          if (cur < 11) att[cur]++;
          cd = 20;
        end
        prev = o_start;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input int maxc, input string tag);
    int k;
    k = 0;
    while (!(o_done || o_error) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(o_done | o_error), 32'd1);
  endtask

  initial begin : main
    int base;
    int bad;
    int k;
    bit found;

    tick(3);
    check("rst_start", 32'(o_start), 32'd0);
    check("rst_data", 32'(o_data), 32'h0000);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_idx", 32'(o_idx), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean sequence, with a go pulse injected while busy.
    base = log_d.size();
    pulse_go();
    check("go_load_busy", 32'(o_busy), 32'd1);
    check("go_load_nostart", 32'(o_start), 32'd0);
    @(negedge clk);
    check("go_start", 32'(o_start), 32'd1);
    check("go_data", 32'(o_data), 32'h1E00);
    tick(30);
    pulse_go();
    check("busy_go_ignored_idx", 32'(o_idx), 32'd1);
    wait_end(2000, "clean_end");
    check("clean_done", 32'(o_done), 32'd1);
    check("clean_error", 32'(o_error), 32'd0);
    check("clean_busy", 32'(o_busy), 32'd0);
    check("clean_idx", 32'(o_idx), 32'd10);
    check("clean_count", 32'(log_d.size() - base), 32'd11);
    for (int j = 0; j < 11; j++)
      if (base + j < log_d.size()) check($sformatf("clean_w%0d", j), 32'(log_d[base + j]), 32'(tbl[j]));
    if (base + 1 < log_c.size())
      check("clean_interval", 32'(log_c[base + 1] - log_c[base]), 32'(20 + 3 + Gap));

    // Single NACK on the first attempt of word 4; go from DONE restarts.
    epoch++;
    nack_idx = 4;
    nack_all = 1'b0;
    base = log_d.size();
    pulse_go();
    check("restart_clears_done", 32'(o_done), 32'd0);
    wait_end(2000, "nack_end");
    check("nack_done", 32'(o_done), 32'd1);
    check("nack_error", 32'(o_error), 32'd0);
    check("nack_count", 32'(log_d.size() - base), 32'd12);
    for (int j = 0; j < 12; j++)
      if (base + j < log_d.size())
        check($sformatf("nack_s%0d", j), 32'(log_d[base + j]), 32'(tbl[(j <= 4) ? j : j - 1]));

    // Every attempt of word 2 NACKed: retries exhaust.
    epoch++;
    nack_idx = 2;
    nack_all = 1'b1;
    base = log_d.size();
    pulse_go();
    wait_end(2000, "exh_end");
    check("exh_error", 32'(o_error), 32'd1);
    check("exh_done", 32'(o_done), 32'd0);
    check("exh_idx", 32'(o_idx), 32'd2);
    check("exh_busy", 32'(o_busy), 32'd0);
    tick(200);
    check("exh_count", 32'(log_d.size() - base), 32'd5);
    for (int j = 2; j < 5; j++)
      if (base + j < log_d.size()) check($sformatf("exh_s%0d", j), 32'(log_d[base + j]), 32'h0217);

    // Word 0 never completes: time-outs; go from ERROR restarts at word 0.
    epoch++;
    nack_idx = -1;
    hold_idx = 0;
    base = log_d.size();
    pulse_go();
    check("err_cleared", 32'(o_error), 32'd0);
    check("err_restart_idx", 32'(o_idx), 32'd0);
    wait_end(1000, "tmo_end");
    check("tmo_error", 32'(o_error), 32'd1);
    check("tmo_idx", 32'(o_idx), 32'd0);
    check("tmo_count", 32'(log_d.size() - base), 32'd3);
    for (int j = 0; j < 3; j++)
      if (base + j < log_d.size()) check($sformatf("tmo_s%0d", j), 32'(log_d[base + j]), 32'h1E00);
    for (int j = 1; j < 3; j++)
      if (base + j < log_c.size())
        check($sformatf("tmo_interval%0d", j), 32'(log_c[base + j] - log_c[base + j - 1]),
              32'(1 + Tmo + 1 + Gap + 1));

    // Ready back-pressure in START.
    hold_idx = -1;
    epoch++;
    rdy = 1'b0;
    pulse_go();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_start !== 1'b0 || o_data !== 16'h1E00) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_busy", 32'(o_busy), 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("bp_start", 32'(o_start), 32'd1);
    check("bp_data", 32'(o_data), 32'h1E00);

    // Reset asserted during the WAIT of word 6.
    found = 1'b0;
    k = 0;
    while (!found && k < 2000) begin
      @(negedge clk);
      k++;
      if (o_start && o_idx == 4'd6) found = 1'b1;
    end
    check("reach_w6", 32'(found), 32'd1);
    tick(3);
    check("w6_busy", 32'(o_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_start", 32'(o_start), 32'd0);
    check("arst_data", 32'(o_data), 32'h0000);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_done", 32'(o_done), 32'd0);
    check("arst_error", 32'(o_error), 32'd0);
    check("arst_idx", 32'(o_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    epoch++;
    base = log_d.size();
    pulse_go();
    wait_end(2000, "rerun_end");
    check("rerun_done", 32'(o_done), 32'd1);
    check("rerun_idx", 32'(o_idx), 32'd10);
    check("rerun_count", 32'(log_d.size() - base), 32'd11);
    if (base < log_d.size()) check("rerun_first", 32'(log_d[base]), 32'h1E00);
    if (base + 10 < log_d.size()) check("rerun_last", 32'(log_d[base + 10]), 32'h1201);

    check("start_protocol", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
